instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Requester side of the instruction-memory interface for the multi-cycle core.
- Owns the program counter and drives the word address into the combinational instruction memory; latches the returned word into an instruction register.
- Presents the latched instruction to decode with a valid/ready handshake.
- Accepts PC redirects from branch/jump resolution.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; low 2 bits must be zero.
- IMEM_BYTES, 1024, size of the instruction memory in bytes (256 words); a PC at or above this faults.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_addr  out  32  byte address to instruction memory; equals pc; memory indexes bits [9:2].
- imem_rdata  in  32  combinational instruction word returned for imem_addr.
- halt  in  1  freezes fetch progress while high; does not block redirect.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  32  new PC target; bits [1:0] are ignored (forced to 0).
- instr_out  out  32  latched instruction register.
- instr_pc  out  32  PC the latched instruction was fetched from.
- instr_valid  out  1  instr_out/instr_pc hold a live instruction.
- instr_ready  in  1  decode accepts the instruction this cycle.
- fetch_fault  out  1  PC out of range; level signal, held until redirect or reset.

Behaviour:
- Internal state: pc (32), state in {FETCH, VALID, FAULT}.
- Reset values: pc = RESET_PC, state = FETCH, instr_out = 0, instr_pc = 0, instr_valid = 0, fetch_fault = 0. Reset overrides everything, including mid-handshake.
- imem_addr = pc, combinationally, in every state.
- FETCH, halt = 0, pc < IMEM_BYTES: at the edge, instr_out <= imem_rdata and instr_pc <= pc; go to VALID.
- FETCH, halt = 0, pc >= IMEM_BYTES: at the edge, go to FAULT; instr_out is not written.
- FETCH, halt = 1: remain in FETCH; no capture.
- instr_valid = 1 exactly when state = VALID (registered). fetch_fault = 1 exactly when state = FAULT.
- VALID with instr_ready = 1 at the edge: handshake completes; pc <= pc + 4 (mod 2^32, so 32'hFFFF_FFFC wraps to 0); go to FETCH.
- VALID with instr_ready = 0: hold instr_out, instr_pc and pc stable.
- halt has no effect in VALID; an already-latched instruction may still be accepted.
- FAULT: remain until redirect or reset; instr_valid = 0.
- Redirect: redirect_valid = 1 at an edge, in any state:
  - pc <= {redirect_pc[31:2], 2'b00}; go to FETCH; any held instruction is discarded, so instr_valid = 0 in the next cycle.
  - Redirect has priority over a same-cycle handshake. If instr_valid & instr_ready & redirect_valid, decode consumes the current instruction and pc takes the redirect target, not pc + 4.
  - Redirect clears FAULT.
- Latency: 1 cycle from entering FETCH to instr_valid; throughput is at most one instruction per 2 cycles.
- instr_out is not cleared when leaving VALID; consumers qualify with instr_valid.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds output fetch_count (32). It resets to 0, increments by 1 on each completed handshake (instr_valid & instr_ready, including the redirect-priority case), and wraps at 2^32.
- Undefined: no port and no counter logic; all other behaviour is identical.

Decomposition:
- Package fetch_pkg holds:
  - fetch_state_t enum (FETCH, VALID, FAULT);
  - INSTR_BYTES = 4;
  - PC_ALIGN_MASK = 32'hFFFF_FFFC;
  - NOP_INSTR = 32'h0000_0013, for bench use.
- One natural sub-module, fetch_pc_reg: the pc register plus next-PC mux (reset / redirect / pc + 4 / hold).
- The FSM and instruction register live in the top module.

Test Plan:
- Reset then instr_ready = 1 held, memory word0 = 32'h003100B3, word1 = 32'h007303B3 -> cycle 2 after reset: instr_valid = 1, instr_out = 32'h003100B3, instr_pc = 0; two cycles later instr_out = 32'h007303B3, instr_pc = 4.
- Backpressure: instr_ready = 0 for 5 cycles while VALID -> instr_out, instr_pc and imem_addr stay constant; ready = 1 -> pc advances to 8.
- Redirect during VALID with ready = 1, redirect_pc = 32'h0000_0013 -> pc = 32'h10, instr_valid = 0 next cycle, then instr_out = memory word4 with instr_pc = 32'h10.
- Out-of-range: redirect_pc = 32'h400 -> after FETCH, fetch_fault = 1 and instr_valid = 0 held 10 cycles; redirect to 0 -> fault clears, word0 delivered.
- halt = 1 in FETCH for 3 cycles -> instr_valid stays 0; halt = 0 -> instr_valid one cycle later. Reset asserted while VALID -> instr_valid = 0 and pc = RESET_PC next cycle.
- FETCH_PERF_CNT_EN defined: 6 handshakes, one coinciding with a redirect -> fetch_count = 6; with the macro undefined the bench elaborates without the port.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// fetch_pkg: shared fetch-unit types and constants
package fetch_pkg;
  typedef enum logic [1:0] {FETCH, VALID, FAULT} fetch_state_t;
  localparam logic [31:0] INSTR_BYTES = 32'd4;
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: imem, redirect and decode handshake bundle (fetch_count with FETCH_PERF_CNT_EN)
interface instr_fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic halt;
  logic redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic instr_valid;
  logic instr_ready;
  logic fetch_fault;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  modport master (output imem_addr, instr_out, instr_pc, instr_valid, fetch_fault, fetch_count,
                  input imem_rdata, halt, redirect_valid, redirect_pc, instr_ready);
  modport slave (input imem_addr, instr_out, instr_pc, instr_valid, fetch_fault, fetch_count,
                 output imem_rdata, halt, redirect_valid, redirect_pc, instr_ready);
`else
  modport master (output imem_addr, instr_out, instr_pc, instr_valid, fetch_fault,
                  input imem_rdata, halt, redirect_valid, redirect_pc, instr_ready);
  modport slave (input imem_addr, instr_out, instr_pc, instr_valid, fetch_fault,
                 output imem_rdata, halt, redirect_valid, redirect_pc, instr_ready);
`endif
endinterface

// File: rtl/instr_fetch_unit_pc_reg.sv
// fetch_pc_reg: program counter with reset / redirect / advance / hold next-PC selection
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        advance,
  output logic [31:0] pc
);
  always_ff @(posedge clk)
    pc <= reset ? RESET_PC
        : redirect_valid ? (redirect_pc & PC_ALIGN_MASK)
        : advance ? pc + INSTR_BYTES
        : pc;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC-driven instruction fetch with decode handshake (fetch_count with FETCH_PERF_CNT_EN)
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] IMEM_BYTES = 32'd1024
) (
  input logic clk,
  input logic reset,
  instr_fetch_unit_if.master bus
);
  localparam logic [1:0] ST_FETCH = 2'(FETCH);
  localparam logic [1:0] ST_VALID = 2'(VALID);
  localparam logic [1:0] ST_FAULT = 2'(FAULT);
  logic [1:0] state;
  logic [31:0] pc;
  logic handshake, capture, in_range, fetching;
  fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk(clk),
    .reset(reset),
    .redirect_valid(bus.redirect_valid),
    .redirect_pc(bus.redirect_pc),
    .advance(handshake),
    .pc(pc)
  );
  assign bus.imem_addr = pc;
  assign bus.instr_valid = state == ST_VALID;
  assign bus.fetch_fault = state == ST_FAULT;
  assign in_range = pc < IMEM_BYTES;
  assign handshake = bus.instr_valid && bus.instr_ready;
  assign fetching = state == ST_FETCH && !bus.halt;
  // a same-cycle redirect wins, so the word addressed by the stale pc is never latched
  assign capture = fetching && in_range && !bus.redirect_valid;
  always_ff @(posedge clk)
    state <= (reset || bus.redirect_valid) ? ST_FETCH
           : fetching ? (in_range ? ST_VALID : ST_FAULT)
           : handshake ? ST_FETCH
           : state;
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.instr_out <= '0;
      bus.instr_pc <= '0;
    end else if (capture) begin
      bus.instr_out <= bus.imem_rdata;
      bus.instr_pc <= pc;
    end
  end
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk)
    bus.fetch_count <= reset ? 32'd0 : handshake ? bus.fetch_count + 32'd1 : bus.fetch_count;
`endif
endmodule
